// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO over a valid/ready stream.
// tx is registered and idles high; frames are sent back to back while bytes are queued.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 6000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg;
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [BAUD_W-1:0] baud_cnt_reg;
    logic [2:0]        bit_idx_reg;
    logic [7:0]        shift_reg;
    logic              tx_reg;
    logic              push;
    logic              pop;
    logic              baud_wrap;
    logic              fifo_empty;

    // in_ready comes from the registered count only, so a same-cycle pop never raises it.
    assign fifo_empty = (count_reg == '0);
    assign in_ready   = (count_reg != CNT_FULL);
    assign push       = in_valid & in_ready;
    assign baud_wrap  = (baud_cnt_reg == BAUD_LAST);
    assign pop        = !fifo_empty && ((state_reg == IDLE) || (state_reg == STOP && baud_wrap));
    assign tx         = tx_reg;
    assign busy       = (state_reg != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // tx lags the state by one edge, so the line changes exactly one cycle after each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg       <= 1'b1;
                    baud_cnt_reg <= '0;
                    bit_idx_reg  <= '0;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_mem[rd_ptr_reg];
                        state_reg <= START;
                    end
                end
                START: begin
                    tx_reg <= 1'b0;
                    if (baud_wrap) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                DATA: begin
                    tx_reg <= shift_reg[0];
                    if (baud_wrap) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        bit_idx_reg  <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                STOP: begin
                    tx_reg <= 1'b1;
                    if (baud_wrap) begin
                        baud_cnt_reg <= '0;
                        bit_idx_reg  <= '0;
                        if (!fifo_empty) begin
                            shift_reg <= fifo_mem[rd_ptr_reg];
                            state_reg <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 6 MHz / 115200 baud (52 clocks per bit), depth 4.
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_uart_tx_fifo;
    localparam int CPB = 52;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLK_FREQ  (6000000),
        .BAUD      (115200),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called right after the rising edge on which tx should fall; returns right after
    // the edge on which the following frame's start bit would begin.
    task automatic expect_frame(input logic [7:0] b, input string tag);
        logic exp_bit;
        for (int bi = 0; bi < 10; bi++) begin
            if (bi == 0)      exp_bit = 1'b0;
            else if (bi == 9) exp_bit = 1'b1;
            else              exp_bit = b[bi-1];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (c == 0 || c == CPB - 1)
                    check($sformatf("%s_bit%0d_c%0d", tag, bi, c), {31'd0, tx}, {31'd0, exp_bit});
                @(posedge clk);
            end
        end
    endtask

    logic       low_seen;
    logic       busy_seen;
    logic       nrdy_seen;
    int         acc_edge [1:6];

    initial begin
        // 1. reset with in_valid high
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        low_seen = 1'b0; busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!tx) low_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check("rst_no_tx", {31'd0, low_seen}, 32'd0);
        check("rst_no_busy", {31'd0, busy_seen}, 32'd0);
        @(posedge clk); #1;

        // 2. single 0x55
        in_valid = 1'b1; in_data = 8'h55;
        @(posedge clk); #1;          // edge N: accepted
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_busy_after_accept", {31'd0, busy}, 32'd1);
        check("t2_tx_n", {31'd0, tx}, 32'd1);
        @(posedge clk);              // edge N+1: pop
        @(negedge clk);
        check("t2_tx_n1", {31'd0, tx}, 32'd1);
        @(posedge clk);              // edge N+2: tx falls
        expect_frame(8'h55, "t2");
        @(negedge clk);
        check("t2_busy_done", {31'd0, busy}, 32'd0);
        check("t2_tx_idle", {31'd0, tx}, 32'd1);
        @(posedge clk); #1;

        // 3. 0xA5 then 0x3C back to back
        in_valid = 1'b1; in_data = 8'hA5;
        @(posedge clk); #1;
        in_data = 8'h3C;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        expect_frame(8'hA5, "t3a");
        expect_frame(8'h3C, "t3b");
        @(negedge clk);
        check("t3_busy_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // 4. in_valid held for bytes 01..06
        fork
            begin
                int edges;
                logic rdy;
                edges = 0;
                for (int k = 1; k <= 6; k++) begin
                    int guard;
                    in_data = 8'(k); in_valid = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge clk);
                        rdy = in_ready;
                        @(posedge clk);
                        edges++;
                        guard++;
                    end while (!rdy && guard < 2000);
                    acc_edge[k] = rdy ? edges : -1;
                    #1;
                    if (k == 5) check("t4_full_not_ready", {31'd0, in_ready}, 32'd0);
                end
                in_valid = 1'b0;
            end
            begin
                @(posedge clk); @(posedge clk); @(posedge clk);
                for (int k = 1; k <= 6; k++)
                    expect_frame(8'(k), $sformatf("t4_f%0d", k));
            end
        join
        for (int k = 1; k <= 5; k++)
            check($sformatf("t4_acc_edge%0d", k), acc_edge[k], k);
        check("t4_acc_edge6", acc_edge[6], 523);
        @(negedge clk);
        check("t4_busy_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // 5. reset during data bit 3 of 0x0F with two bytes queued
        in_valid = 1'b1; in_data = 8'h0F;
        @(posedge clk); #1;          // edge 1 (N)
        in_data = 8'hAA;
        @(posedge clk); #1;          // edge 2
        in_data = 8'hBB;
        @(posedge clk); #1;          // edge 3
        in_valid = 1'b0;
        repeat (227) @(posedge clk); // edge 230, inside bit 3 (N+210..N+261)
        @(negedge clk);
        check("t5_bit3_tx", {31'd0, tx}, 32'd1);
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        check("t5_queued_not_full", {31'd0, in_ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_tx_after_rst", {31'd0, tx}, 32'd1);
        check("t5_busy_after_rst", {31'd0, busy}, 32'd0);
        check("t5_ready_after_rst", {31'd0, in_ready}, 32'd1);
        low_seen = 1'b0; busy_seen = 1'b0;
        repeat (1200) begin
            @(negedge clk);
            if (!tx) low_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check("t5_no_frames", {31'd0, low_seen}, 32'd0);
        check("t5_no_busy", {31'd0, busy_seen}, 32'd0);
        @(posedge clk); #1;

        // 6. in_data toggling with in_valid low
        low_seen = 1'b0; busy_seen = 1'b0; nrdy_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            in_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
            @(negedge clk);
            if (!tx) low_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (!in_ready) nrdy_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("t6_tx_high", {31'd0, low_seen}, 32'd0);
        check("t6_busy_low", {31'd0, busy_seen}, 32'd0);
        check("t6_ready_high", {31'd0, nrdy_seen}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
